// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg
//   Shared types and constants for the FIFO-fed UART transmitter.
//   - tx_state_t : transmitter FSM state encoding (3 bits)
//   - LINE_IDLE  : serial line level while idle and during stop bits
//   - LINE_START : serial line level of the start bit
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } tx_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// baud_tick
//   Bit-period counter for the UART transmitter. Counts clk cycles within
//   one serial bit and flags the last cycle of that bit.
//   Ports:
//     clk    in  system clock
//     nreset in  asynchronous active-low reset
//     clear  in  hold the counter at 0 (used while no bit is on the line)
//     tick   out high on the last cycle of a bit
module baud_tick #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic nreset,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign tick = (cnt_reg == CNT_LAST);

  // Reload on every bit end so the count restarts in step with each new
  // bit; it never wraps in the middle of a bit.
  always_comb begin
    cnt_next = cnt_reg + CNT_W'(1);
    if (clear || tick) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Sole reader of the upstream byte FIFO. When enabled and the FIFO is not
//   empty it pops one word and sends it LSB-first as an asynchronous serial
//   frame: one start bit, DATA_WIDTH data bits, STOP_BITS stop bits.
//   Ports:
//     clk          in  system clock
//     nreset       in  asynchronous active-low reset
//     enable_i     in  permits a new frame; only looked at in IDLE
//     fifo_empty_i in  FIFO empty flag
//     fifo_data_i  in  FIFO registered read data (valid the cycle after a pop)
//     fifo_read_o  out one-cycle pop request per word
//     tx_o         out registered serial line, idles high
//     busy_o       out high whenever a frame is being fetched or sent
//     sent_o       out one-cycle pulse when the last stop bit completes
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 104,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  enable_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_read_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  sent_o
);

  localparam int               IDX_W     = $clog2(DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
  // Value of the 1-bit stop counter during the final stop bit.
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  tx_state_t             state_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [IDX_W-1:0]      bit_idx_reg;
  logic                  stop_cnt_reg;
  logic                  tx_reg;
  logic                  sent_reg;
  logic                  baud_clear;
  logic                  bit_end;

  // The bit timer only runs while a bit is on the line; holding it clear
  // through IDLE/FETCH/LOAD makes the start bit begin with a count of 0.
  assign baud_clear = (state_reg == ST_IDLE) || (state_reg == ST_FETCH) ||
                      (state_reg == ST_LOAD);

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk   (clk),
    .nreset(nreset),
    .clear (baud_clear),
    .tick  (bit_end)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      tx_reg       <= LINE_IDLE;
      sent_reg     <= 1'b0;
    end else begin
      sent_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (enable_i && !fifo_empty_i) begin
            state_reg <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_reg <= ST_LOAD;
        end
        ST_LOAD: begin
          // Read data from the pop issued in FETCH is valid now.
          shift_reg    <= fifo_data_i;
          bit_idx_reg  <= '0;
          stop_cnt_reg <= 1'b0;
          tx_reg       <= LINE_START;
          state_reg    <= ST_START;
        end
        ST_START: begin
          if (bit_end) begin
            tx_reg    <= shift_reg[0];
            state_reg <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            shift_reg   <= shift_reg >> 1;
            bit_idx_reg <= bit_idx_reg + IDX_W'(1);
            if (bit_idx_reg == IDX_LAST) begin
              tx_reg    <= LINE_IDLE;
              state_reg <= ST_STOP;
            end else begin
              // Next bit is shift_reg[1] before the shift lands.
              tx_reg <= shift_reg[1];
            end
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (stop_cnt_reg == STOP_LAST) begin
              sent_reg  <= 1'b1;
              state_reg <= ST_IDLE;
            end else begin
              stop_cnt_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_read_o = (state_reg == ST_FETCH);
  assign busy_o      = (state_reg != ST_IDLE);
  assign tx_o        = tx_reg;
  assign sent_o      = sent_reg;

endmodule
